// File: rtl/double_tokens_gen_pkg.sv
// Shared definitions for the token doubler.
//   CNT_W_DEF   : default width of the pending-token counter
//   pending_t   : pending-token count type at the default width
//   MAX_PENDING : largest backlog the default-width counter can hold
package double_tokens_gen_pkg;

    localparam int CNT_W_DEF = 8;

    typedef logic [CNT_W_DEF-1:0] pending_t;

    localparam pending_t MAX_PENDING = {CNT_W_DEF{1'b1}};

endpackage : double_tokens_gen_pkg

// File: rtl/double_tokens_gen_if.sv
// Token bus between a producer, the doubler and a consumer.
//   a        : input token strobe (producer -> doubler)
//   b        : output token strobe (doubler -> consumer)
//   overflow : sticky backlog-overflow flag (doubler -> observer)
// The master modport is the producer/observer side; the slave modport is the doubler.
interface double_tokens_gen_if;

    logic a;
    logic b;
    logic overflow;

    modport master (
        output a,
        input  b,
        input  overflow
    );

    modport slave (
        input  a,
        output b,
        output overflow
    );

endinterface : double_tokens_gen_if

// File: rtl/double_tokens_gen_counter.sv
// Saturating up/down counter holding the pending-token backlog.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset, clears the count
//   i_inc2    : add two tokens this cycle
//   i_dec1    : remove one token this cycle
//   o_count   : current backlog
//   o_sat_hit : the update computed this cycle exceeds capacity and is clamped
module sat_updown_counter
    import double_tokens_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc2,
    input  logic             i_dec1,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat_hit
);

    localparam logic [CNT_W:0] L_MAX  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0] L_ZERO = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0] L_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] L_TWO  = L_ONE + L_ONE;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_next;
    logic             w_dec_ok;
    logic             w_sat;

    // Next-count arithmetic, one bit wider than the count so overshoot is visible.
    always_comb begin
        w_sum    = L_ZERO;
        w_next   = L_ZERO;
        w_sat    = 1'b0;
        // A decrement with nothing pending and nothing arriving would wrap; ignore it.
        w_dec_ok = i_dec1 & (i_inc2 | (r_count != {CNT_W{1'b0}}));
        w_sum    = {1'b0, r_count} + (i_inc2 ? L_TWO : L_ZERO) - (w_dec_ok ? L_ONE : L_ZERO);
        if (w_sum > L_MAX) begin
            w_next = L_MAX;
            w_sat  = 1'b1;
        end else begin
            w_next = w_sum;
            w_sat  = 1'b0;
        end
    end

    // Backlog register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= w_next[CNT_W-1:0];
        end
    end

    assign o_count   = r_count;
    assign o_sat_hit = w_sat;

endmodule : sat_updown_counter

// File: rtl/double_tokens_gen.sv
// Token doubler: each input token produces two output tokens, emitted as
// early as possible; tokens not yet emitted wait in a saturating counter.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : token interface (slave side) carrying a, b and overflow
// b is combinational (zero latency on the first token of a burst);
// overflow is registered and sticky until reset.
module double_tokens_gen
    import double_tokens_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    double_tokens_gen_if.slave   bus
);

    logic             w_a;
    logic             w_b;
    logic             w_busy;
    logic             w_sat_hit;
    logic [CNT_W-1:0] w_count;
    logic             r_overflow;

    // Mask a while in reset so an undriven/X strobe cannot reach the counter.
    assign w_a    = rst & bus.a;
    assign w_busy = (w_count != {CNT_W{1'b0}});
    assign w_b    = rst & (w_a | w_busy);

    sat_updown_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .i_inc2    (w_a),
        .i_dec1    (w_b),
        .o_count   (w_count),
        .o_sat_hit (w_sat_hit)
    );

    // Sticky overflow: set on the edge that clamps the counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_sat_hit) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign bus.b        = w_b;
    assign bus.overflow = r_overflow;

endmodule : double_tokens_gen

// File: tb/tb_double_tokens_gen.sv
module tb_double_tokens_gen;
    import double_tokens_gen_pkg::*;

    localparam int MAXP = (1 << CNT_W_DEF) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   m_pend;
    logic m_ov;
    logic q_b[$];
    logic q_ov[$];

    double_tokens_gen_if intf ();

    double_tokens_gen #(.CNT_W(CNT_W_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of a, push the reference model's expectations, sample the DUT.
    task automatic drive(input logic av, output logic got_b, output logic got_ov);
        int   nxt;
        logic eb;
        @(negedge clk);
        intf.a = av;
        eb  = av | (m_pend != 0);
        nxt = m_pend + (av ? 2 : 0) - (eb ? 1 : 0);
        if (nxt > MAXP) begin
            m_pend = MAXP;
            m_ov   = 1'b1;
        end else begin
            m_pend = nxt;
        end
        q_b.push_back(eb);
        q_ov.push_back(m_ov);
        #1;
        got_b = intf.b;
        @(posedge clk);
        #1;
        got_ov = intf.overflow;
    endtask

    task automatic test_reset();
        logic gb, gov, eb, eo;
        rst    = 1'b0;
        intf.a = 1'bx;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (intf.b !== 1'b0) begin
            n_fail++; $display("FAIL reset_b: got %b expected 0", intf.b);
        end
        n_checks++;
        if (intf.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b expected 0", intf.overflow);
        end
        intf.a = 1'b0;
        rst    = 1'b1;
        m_pend = 0;
        m_ov   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            n_checks++;
            if (gb !== eb) begin n_fail++; $display("FAIL reset_idle_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL reset_idle_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
    endtask

    task automatic test_single_token();
        logic gb, gov, eb, eo;
        logic pat[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int   nb = 0;
        for (int i = 0; i < 5; i++) begin
            drive(pat[i], gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            if (gb === 1'b1) nb++;
            n_checks++;
            if (gb !== eb) begin n_fail++; $display("FAIL single_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL single_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
        n_checks++;
        if (nb !== 2) begin n_fail++; $display("FAIL single_count: got %0d b tokens expected 2", nb); end
    endtask

    task automatic test_random();
        logic gb, gov, eb, eo, av;
        int   na = 0;
        int   nb = 0;
        for (int i = 0; i < 300; i++) begin
            av = (i < 100) ? ($urandom_range(99) < 30) : 1'b0;
            if (av) na++;
            drive(av, gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            if (gb === 1'b1) nb++;
            n_checks++;
            if (gb !== eb) begin n_fail++; $display("FAIL random_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL random_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
        n_checks++;
        if (nb !== 2 * na) begin n_fail++; $display("FAIL random_total: got %0d b tokens expected %0d", nb, 2 * na); end
        n_checks++;
        if (intf.overflow !== 1'b0) begin n_fail++; $display("FAIL random_overflow: got %b expected 0", intf.overflow); end
    endtask

    task automatic test_half_duty();
        logic gb, gov, eb, eo;
        for (int i = 0; i < 20; i++) begin
            drive(((i % 2) == 0) ? 1'b1 : 1'b0, gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            n_checks++;
            if (gb !== eb || gb !== 1'b1) begin n_fail++; $display("FAIL half_duty_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL half_duty_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
        // Backlog at most 1: output must already be idle on the first a=0 cycle after the run.
        drive(1'b0, gb, gov);
        eb = q_b.pop_front(); eo = q_ov.pop_front();
        n_checks++;
        if (gb !== eb || gb !== 1'b0) begin n_fail++; $display("FAIL half_duty_drain: got %b expected %b", gb, eb); end
    endtask

    task automatic test_saturation();
        logic gb, gov, eb, eo;
        int   first_ov = 0;
        for (int i = 1; i <= 1000; i++) begin
            drive(1'b1, gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            if (gov === 1'b1 && first_ov == 0) first_ov = i;
            n_checks++;
            if (gb !== eb) begin n_fail++; $display("FAIL sat_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL sat_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
        n_checks++;
        if (first_ov != 256) begin n_fail++; $display("FAIL sat_first_ov: got cycle %0d expected 256", first_ov); end
        // Drain to a backlog of 5 while overflow must stay set.
        for (int i = 0; i < MAXP - 5; i++) begin
            drive(1'b0, gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            n_checks++;
            if (gb !== eb) begin n_fail++; $display("FAIL sat_drain_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL sat_drain_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
    endtask

    task automatic test_midrun_reset();
        logic gb, gov, eb, eo;
        logic pat[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (m_pend != 5 || intf.b !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_b: got %b expected 1 with backlog %0d", intf.b, m_pend); end
        @(negedge clk);
        rst    = 1'b0;
        intf.a = 1'bx;
        #1;
        n_checks++;
        if (intf.b !== 1'b0) begin n_fail++; $display("FAIL midrun_b: got %b expected 0", intf.b); end
        n_checks++;
        if (intf.overflow !== 1'b0) begin n_fail++; $display("FAIL midrun_overflow: got %b expected 0", intf.overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        intf.a = 1'b0;
        rst    = 1'b1;
        m_pend = 0;
        m_ov   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(pat[i], gb, gov);
            eb = q_b.pop_front(); eo = q_ov.pop_front();
            n_checks++;
            if (gb !== eb) begin n_fail++; $display("FAIL midrun_post_b cyc %0d: got %b expected %b", i, gb, eb); end
            n_checks++;
            if (gov !== eo) begin n_fail++; $display("FAIL midrun_post_ov cyc %0d: got %b expected %b", i, gov, eo); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_pend   = 0;
        m_ov     = 1'b0;
        rst      = 1'b0;
        intf.a   = 1'b0;
        test_reset();
        test_single_token();
        test_random();
        test_half_duty();
        test_saturation();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_double_tokens_gen
